apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- APB3-style completer: a 32-word x 32-bit register file reached through a single APB port.
- Handles SETUP/ACCESS phases with a fixed, parameterised number of wait states.
- Signals errors through pslverr.
- Sits behind the system APB interconnect as a leaf peripheral.

Parameters:
- DATA_W, 32, width of pwdata, prdata and each storage word.
- ADDR_W, 5, width of addr (word address).
- DEPTH, 32, number of implemented words; addresses >= DEPTH are unmapped.
- WAIT_STATES, 1, number of ACCESS cycles with pready low before the completing cycle (0 allowed).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- psel  input  1  slave select.
- penable  input  1  ACCESS-phase strobe.
- pwrite  input  1  1 = write, 0 = read.
- addr  input  ADDR_W  word address.
- pwdata  input  DATA_W  write data.
- pready  output  1  transfer complete, one-cycle pulse.
- pslverr  output  1  error response; valid only while pready = 1.
- prdata  output  DATA_W  read data.

Interface decisions: one clock, clk; reset is asynchronous and active-low, named resetn.

Behaviour:
- Reset (resetn = 0, asynchronous):
  - FSM to IDLE; wait counter to 0.
  - All DEPTH words cleared to 0.
  - pready = 0, pslverr = 0, prdata = 0.
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered or decoded from registered state only.
- Transitions:
  - IDLE: psel & !penable -> SETUP. psel & penable without a prior SETUP -> stays IDLE, ignored, no error.
  - SETUP: latch addr, pwrite and pwdata. Next edge with psel & penable -> ACCESS with counter = 0. psel & !penable -> stay SETUP and relatch. !psel -> IDLE.
  - ACCESS: counter increments each cycle. The transfer completes in the cycle where counter == WAIT_STATES; pready = 1 for that cycle only, then -> DONE.
  - DONE: holds while penable = 1, so no second transfer is triggered. penable = 0 with psel = 1 -> SETUP (back-to-back transfer). !psel -> IDLE.
  - psel or penable dropping during ACCESS before completion: abort, no write, no pready, -> IDLE.
- Latency: with WAIT_STATES = N, pready rises N+1 edges after penable is first sampled high. The default gives 1 wait cycle.
- Write: the word is written on the completing edge, exactly once per transfer, using latched addr and pwdata.
- Read: prdata loads mem[latched addr] on the completing edge and holds that value until the next completed read. Read-after-write to the same address returns the new data.
- pslverr is asserted with pready, otherwise 0. It is set when:
  - the latched addr >= DEPTH: write suppressed, prdata = 0 on reads;
  - addr or pwrite changed between SETUP and completion: write suppressed, prdata unchanged.
- Reset mid-transfer: immediate return to reset values; the pending write is lost.

Decomposition:
- Package apb_pkg holds:
  - the state enum typedef (IDLE/SETUP/ACCESS/DONE);
  - the default widths DATA_W and ADDR_W;
  - the OKAY/ERROR response constants.
- One sub-module, apb_regfile_mem: synchronous-write, registered-read, DEPTH x DATA_W storage with asynchronous clear.
- The FSM, wait counter and error check stay in the top.

Test Plan:
- Reset: hold resetn = 0 for 1 cycle, release -> pready = 0, pslverr = 0, prdata = 0; a read of addr 0 returns 0.
- Write, then read:
  - Write 0x12153524 to addr 0x01 -> pready pulses once, 2 edges after penable rises, pslverr = 0.
  - Read addr 0x01 -> prdata = 0x12153524.
- Master holds penable 2 extra cycles after pready -> FSM stays in DONE, no second pready, word written once. A following psel = 1, penable = 0, pwrite = 0 cycle starts a clean read.
- Back-to-back writes: 0xDEADBEEF to 0x1F, then 0x00000005 to 0x00 -> reads return those values, and other addresses still read 0.
- Error: with DEPTH = 16, write to 0x14 -> pready = 1 with pslverr = 1, memory unchanged. Change addr during ACCESS -> pslverr = 1, no write.
- Reset asserted during ACCESS of a write of 0xA5A5A5A5 -> outputs return to 0 asynchronously, and the target word reads 0 afterwards.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register file slice.
// Default bus widths, response codes and the completer state encoding.
package apb_pkg;

  localparam int DFLT_DATA_W = 32;
  localparam int DFLT_ADDR_W = 5;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

endpackage

// File: rtl/apb_regfile_mem.sv
// DEPTH x DATA_W storage: synchronous write, registered read port.
// Out-of-range accesses never touch storage and read back as zero.
module apb_regfile_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              w_ok;
  logic              r_ok;

  assign w_ok = int'(waddr) < DEPTH;
  assign r_ok = int'(raddr) < DEPTH;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we && w_ok) begin
        mem[waddr[IW-1:0]] <= wdata;
      end
      if (re) begin
        rdata <= r_ok ? mem[raddr[IW-1:0]] : '0;
      end
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer in front of a register file, fixed wait states.
// Read data and error status are settled on the edge entering the pready cycle.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DATA_W      = DFLT_DATA_W,
  parameter int ADDR_W      = DFLT_ADDR_W,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] prdata
);

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] WS = CW'(WAIT_STATES);

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_write;
  logic [DATA_W-1:0] lat_wdata;
  logic              chg;
  logic              err;

  logic xfer;
  logic setup_req;
  logic mismatch;
  logic oob;
  logic last;
  logic fire;
  logic latch;
  logic track;
  logic we;
  logic re;

  assign xfer      = psel & penable;
  assign setup_req = psel & ~penable;
  assign mismatch  = (addr != lat_addr) || (pwrite != lat_write);
  assign oob       = int'(lat_addr) >= DEPTH;
  assign last      = (state == ACCESS) && (cnt == WS);

  // fire: the edge that opens the completing cycle
  assign fire = xfer &&
    (((state == SETUP) && (WAIT_STATES == 0)) ||
     ((state == ACCESS) && !last && (cnt + CW'(1) == WS)));

  assign latch = setup_req && (state != ACCESS);
  assign track = xfer && ((state == SETUP) || ((state == ACCESS) && !last));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (setup_req) state_nxt = SETUP;
      end
      SETUP: begin
        if (!psel) begin
          state_nxt = IDLE;
        end else if (penable) begin
          state_nxt = ACCESS;
          cnt_nxt   = '0;
        end
      end
      ACCESS: begin
        if (last) begin
          state_nxt = DONE;
        end else if (!xfer) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        if (!psel) begin
          state_nxt = IDLE;
        end else if (!penable) begin
          state_nxt = SETUP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      chg       <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (latch) begin
        lat_addr  <= addr;
        lat_write <= pwrite;
        lat_wdata <= pwdata;
        chg       <= 1'b0;
      end else if (track) begin
        chg <= chg | mismatch;
      end
      if (fire) begin
        err <= oob | chg | mismatch;
      end
    end
  end

  assign we = last && lat_write && !err;
  assign re = fire && !lat_write && !(chg || mismatch);

  apb_regfile_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .resetn(resetn),
    .we    (we),
    .waddr (lat_addr),
    .wdata (lat_wdata),
    .re    (re),
    .raddr (lat_addr),
    .rdata (prdata)
  );

  assign pready  = last;
  assign pslverr = (last && err) ? RESP_ERROR : RESP_OKAY;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomised APB master against two completers (DEPTH 32 and 16).
// Expected values come from a word-array model of the register file.
module tb_apb_slave_regfile;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] pwdata = '0;

  logic        pready_a, pslverr_a;
  logic [31:0] prdata_a;
  logic        pready_b, pslverr_b;
  logic [31:0] prdata_b;

  int vectors = 0;
  int errors = 0;

  logic [31:0] ref_mem [2][32];
  logic [31:0] ref_rd [2];
  int          depth_of [2] = '{32, 16};

  always #5 clk = ~clk;

  apb_slave_regfile #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(32), .WAIT_STATES(1)
  ) dut_a (
    .clk(clk), .resetn(resetn), .psel(psel), .penable(penable),
    .pwrite(pwrite), .addr(addr), .pwdata(pwdata),
    .pready(pready_a), .pslverr(pslverr_a), .prdata(prdata_a)
  );

  apb_slave_regfile #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(16), .WAIT_STATES(1)
  ) dut_b (
    .clk(clk), .resetn(resetn), .psel(psel), .penable(penable),
    .pwrite(pwrite), .addr(addr), .pwdata(pwdata),
    .pready(pready_b), .pslverr(pslverr_b), .prdata(prdata_b)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) ref_mem[k][i] = '0;
      ref_rd[k] = '0;
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    psel = 1'b0;
    penable = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // mode: 0 plain, 1 addr moves during ACCESS, 2 abort, 3 hold penable
  task automatic xfer(input bit w, input logic [4:0] a,
                      input logic [31:0] d, input int mode);
    int  edges;
    bit  seen;
    bit  moved;
    bit  e;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; addr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    if (mode == 2) begin
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        check("abort_pready", {31'b0, pready_a | pready_b}, 32'd0);
      end
      return;
    end
    edges = 0;
    seen = 1'b0;
    moved = (mode == 1);
    while (!seen && edges < 8) begin
      @(posedge clk); #1;
      edges++;
      if (pready_a) seen = 1'b1;
      else if (moved && edges == 1) addr = a ^ 5'h01;
    end
    check("latency", 32'(edges), 32'd2);
    check("pready_b", {31'b0, pready_b}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      e = (int'(a) >= depth_of[k]) || moved;
      if (w && !e) ref_mem[k][a] = d;
      if (!w && !moved) ref_rd[k] = (int'(a) >= depth_of[k]) ? '0 : ref_mem[k][a];
      check(k == 0 ? "pslverr_a" : "pslverr_b",
            {31'b0, k == 0 ? pslverr_a : pslverr_b}, {31'b0, e});
    end
    check("prdata_a", prdata_a, ref_rd[0]);
    check("prdata_b", prdata_b, ref_rd[1]);
    if (mode == 3) begin
      repeat (2) begin
        @(posedge clk); #1;
        check("hold_pready", {31'b0, pready_a | pready_b}, 32'd0);
      end
    end
  endtask

  initial begin
    model_clear();
    @(posedge clk); #1;
    check("rst_pready", {31'b0, pready_a | pready_b}, 32'd0);
    check("rst_pslverr", {31'b0, pslverr_a | pslverr_b}, 32'd0);
    check("rst_prdata_a", prdata_a, 32'd0);
    check("rst_prdata_b", prdata_b, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    xfer(1'b0, 5'h00, 32'h0, 0);
    xfer(1'b1, 5'h01, 32'h12153524, 0);
    xfer(1'b0, 5'h01, 32'h0, 0);
    xfer(1'b1, 5'h03, 32'hCAFEF00D, 3);
    xfer(1'b0, 5'h03, 32'h0, 0);
    xfer(1'b1, 5'h1F, 32'hDEADBEEF, 0);
    xfer(1'b1, 5'h00, 32'h00000005, 0);
    xfer(1'b0, 5'h1F, 32'h0, 0);
    xfer(1'b0, 5'h00, 32'h0, 0);
    xfer(1'b0, 5'h05, 32'h0, 0);
    xfer(1'b1, 5'h14, 32'h55AA55AA, 0);
    xfer(1'b0, 5'h14, 32'h0, 0);
    xfer(1'b1, 5'h06, 32'h00000077, 1);
    xfer(1'b0, 5'h06, 32'h0, 0);
    xfer(1'b0, 5'h07, 32'h0, 0);
    xfer(1'b1, 5'h08, 32'h0BADF00D, 2);
    xfer(1'b0, 5'h08, 32'h0, 0);

    idle(2);
    psel = 1'b1; penable = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("no_setup_pready", {31'b0, pready_a | pready_b}, 32'd0);
    end
    idle(1);

    xfer(1'b0, 5'h01, 32'h0, 0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    addr = 5'h09; pwdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    check("midrst_pready", {31'b0, pready_a | pready_b}, 32'd0);
    check("midrst_pslverr", {31'b0, pslverr_a | pslverr_b}, 32'd0);
    check("midrst_prdata_a", prdata_a, 32'd0);
    check("midrst_prdata_b", prdata_b, 32'd0);
    model_clear();
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    xfer(1'b0, 5'h09, 32'h0, 0);
    xfer(1'b0, 5'h01, 32'h0, 0);

    for (int n = 0; n < 300; n++) begin
      int r;
      int mode;
      r = int'($urandom_range(0, 99));
      mode = (r < 10) ? 1 : (r < 15) ? 2 : (r < 25) ? 3 : 0;
      xfer(1'($urandom), 5'($urandom), $urandom, mode);
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
